// File: rtl/data_memory_pipe.sv
// Byte-lane data memory with a valid/ready request port, a READ_LATENCY-deep read response pipe and a hardware zero-fill after reset.
// Read latency is READ_LATENCY cycles from accept. ReqReady is low only while the INIT clear runs, and there is no response backpressure.
// DMEM_ERR_RESP_EN flags and suppresses misaligned or out-of-range accesses. Without it, addresses wrap modulo DEPTH.
module data_memory_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic                    RespValid,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    AddrError
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    addr_bad;
    logic [IDX_W-1:0]        acc_idx;

    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   wr_dat;
    logic [NB-1:0]           wr_be;
    logic [DATA_WIDTH-1:0]   rd_merged;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_dat_d [READ_LATENCY];

    assign word_idx = Address >> OFF_W;

`ifdef DMEM_ERR_RESP_EN
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);
    logic err_q, err_d;

    assign addr_bad = (|(Address & OFF_MASK)) || (word_idx >= ADDR_WIDTH'(DEPTH));
    assign acc_idx  = IDX_W'(word_idx);
    assign err_d    = accept && addr_bad;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign AddrError = err_q;
`else
    assign addr_bad  = 1'b0;
    assign acc_idx   = IDX_W'(word_idx % ADDR_WIDTH'(DEPTH));
    assign AddrError = 1'b0;
`endif

    // INIT owns the write port until every word has been zeroed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = acc_idx;
        wr_dat  = WriteData;
        wr_be   = ByteEn;
        case (state_q)
            ST_INIT: begin
                wr_en  = 1'b1;
                wr_idx = cnt_q;
                wr_dat = '0;
                wr_be  = '1;
                cnt_d  = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                accept = ReqValid;
                wr_en  = ReqValid && MemWrite && !addr_bad;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign ReqReady = (state_q == ST_RUN);

    // Write-first: a combined read+write returns the merged post-write word
    always_comb begin
        rd_merged = mem_q[acc_idx];
        if (MemWrite) begin
            for (int b = 0; b < NB; b++) begin
                if (ByteEn[b]) begin
                    rd_merged[b*8 +: 8] = WriteData[b*8 +: 8];
                end
            end
        end
        if (addr_bad) begin
            rd_merged = '0;
        end
    end

    always_comb begin
        pipe_vld_d    = '0;
        pipe_dat_d    = pipe_dat_q;
        pipe_vld_d[0] = accept && MemRead;
        if (accept && MemRead) begin
            pipe_dat_d[0] = rd_merged;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_dat_d[i] = pipe_dat_q[i-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    // The array itself has no reset; the INIT sweep clears it
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    assign RespValid = pipe_vld_q[READ_LATENCY-1];
    assign ReadData  = pipe_dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Randomized and directed bench for data_memory_pipe against a word-array/response-queue model.
module tb_data_memory_pipe;
    localparam int DEPTH = 32;
    localparam int L     = 3;

    logic        Clk;
    logic        Rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic        MemRead;
    logic        MemWrite;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        AddrError;

    data_memory_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(L)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Address(Address), .WriteData(WriteData), .ByteEn(ByteEn),
        .MemRead(MemRead), .MemWrite(MemWrite), .RespValid(RespValid),
        .ReadData(ReadData), .AddrError(AddrError)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        int          due;
        logic [31:0] dat;
    } pend_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          init_left = DEPTH;
    int          err_seen = 0;
    logic [31:0] mm [DEPTH];
    pend_t       pend [$];
    logic [31:0] seen [$];
    logic        exp_err;
    logic [31:0] exp_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        pend.delete();
        init_left = DEPTH;
        exp_err   = 1'b0;
        exp_rd    = 32'h0;
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    endtask

    task automatic mstep();
        logic [31:0] a;
        logic [31:0] w;
        int          idx;
        logic        bad;
        cyc++;
        exp_err = 1'b0;
        if (init_left > 0) begin
            init_left--;
        end else if (ReqValid) begin
            a = Address;
`ifdef DMEM_ERR_RESP_EN
            bad     = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
            idx     = bad ? 0 : int'(a >> 2);
            exp_err = bad;
`else
            bad = 1'b0;
            idx = int'((a >> 2) % DEPTH);
`endif
            if (MemWrite && !bad) begin
                for (int b = 0; b < 4; b++)
                    if (ByteEn[b]) mm[idx][8*b +: 8] = WriteData[8*b +: 8];
            end
            if (MemRead) begin
                w = bad ? 32'h0 : mm[idx];
                pend.push_back('{cyc + L - 1, w});
            end
        end
    endtask

    // Per-cycle compare against the model
    always begin
        logic exp_vld;
        @(posedge Clk);
        #1;
        if (!Rst_n) mreset();
        else        mstep();
        exp_vld = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_vld = 1'b1;
            exp_rd  = pend[0].dat;
            void'(pend.pop_front());
        end
        chk("req_ready", {31'h0, ReqReady}, {31'h0, init_left == 0});
        chk("resp_valid", {31'h0, RespValid}, {31'h0, exp_vld});
        chk("read_data", ReadData, exp_rd);
        chk("addr_error", {31'h0, AddrError}, {31'h0, exp_err});
        if (RespValid) seen.push_back(ReadData);
        if (AddrError) err_seen++;
    end

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge Clk);
        ReqValid = v; MemRead = rd; MemWrite = wr;
        Address = a; WriteData = wd; ByteEn = be;
    endtask

    task automatic idle_wait(input int n);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset(output int n);
        @(negedge Clk);
        Rst_n = 1'b0; ReqValid = 1'b0;
        @(negedge Clk);
        chk("rst_ready", {31'h0, ReqReady}, 32'h0);
        chk("rst_resp_valid", {31'h0, RespValid}, 32'h0);
        chk("rst_read_data", ReadData, 32'h0);
        chk("rst_addr_error", {31'h0, AddrError}, 32'h0);
        Rst_n = 1'b1;
        n = 0;
        while (!ReqReady && n < 200) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic chk_seen(input string nm, input int idx, input logic [31:0] exp);
        if (seen.size() > idx) chk(nm, seen[idx], exp);
        else                   chk({nm, "_missing"}, 32'h0, 32'h1);
    endtask

    initial begin
        int          n;
        int          lat;
        int          nz;
        int          e0;
        int          r;
        logic [31:0] a;
        Rst_n = 1'b0; ReqValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 32'h0; WriteData = 32'h0; ByteEn = 4'h0;

        do_reset(n);
        chk("init_cycles", n, DEPTH);

        // Every word reads back zero after INIT
        seen.delete();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0);
        idle_wait(L + 2);
        chk("zero_read_count", seen.size(), DEPTH);
        nz = 0;
        foreach (seen[i]) if (seen[i] != 32'h0) nz++;
        chk("zero_read_nonzero", nz, 0);

        // Full write then read with latency measurement
        drive(1'b1, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        seen.delete();
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        @(posedge Clk);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (RespValid) begin
                lat = k;
                break;
            end
            @(negedge Clk);
            ReqValid = 1'b0;
            @(posedge Clk);
        end
        chk("read_latency", lat, L);
        idle_wait(L + 2);
        chk_seen("deadbeef", 0, 32'hDEADBEEF);

        // Partial byte-lane write
        seen.delete();
        drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        idle_wait(L + 2);
        chk_seen("byte_lanes", 0, 32'hDE22BE44);

        // Combined read+write, then back-to-back reads
        seen.delete();
        drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        idle_wait(L + 2);
        chk("b2b_count", seen.size(), 4);
        chk_seen("rw_merged", 0, 32'hA5A5A5A5);
        chk_seen("b2b_0", 1, 32'h0);
        chk_seen("b2b_1", 2, 32'h0);
        chk_seen("b2b_2", 3, 32'hDE22BE44);

        // Bad-address handling
        seen.delete();
        e0 = err_seen;
`ifdef DMEM_ERR_RESP_EN
        drive(1'b1, 1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        idle_wait(L + 2);
        chk("err_pulses", err_seen - e0, 2);
        chk_seen("bad_read_zero", 0, 32'h0);
        chk_seen("misaligned_no_write", 1, 32'h0);
`else
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h12345678, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_wait(L + 2);
        chk("err_pulses", err_seen - e0, 0);
        chk_seen("wrap_word0", 0, 32'h12345678);
`endif

        // Reset one cycle after a read accept drops the response
        seen.delete();
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        do_reset(n);
        chk("reinit_cycles", n, DEPTH);
        idle_wait(L + 2);
        chk("dropped_resp", seen.size(), 0);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        idle_wait(L + 2);
        chk_seen("cleared_after_reinit", 0, 32'h0);

        // Random traffic, with one reset part-way through
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge Clk);
                Rst_n = 1'b0;
                @(negedge Clk);
                Rst_n = 1'b1;
            end
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 7) a = 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (r == 8) a = 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 64));
            else             a = $urandom;
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a, $urandom, 4'($urandom_range(0, 15)));
        end
        idle_wait(L + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
- Parametrised successor to the single-cycle data memory: configurable data width, depth and read latency.
- Adds byte-lane writes, a valid/ready request handshake, a pipelined read response, and hardware zero-fill after reset (replaces the simulation-only initial clear).
- Sits between the datapath load/store stage and the memory array; serves one request per cycle once initialised.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8, minimum 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 32, number of words; need not be a power of two.
- READ_LATENCY, 1, cycles from accepted read to RespValid; legal range 1..4.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  request present this cycle.
- ReqReady  out  1  block can accept a request; a request is accepted when ReqValid && ReqReady at posedge.
- Address  in  ADDR_WIDTH  byte address.
- WriteData  in  DATA_WIDTH  store data.
- ByteEn  in  DATA_WIDTH/8  per-byte write enable.
- MemRead  in  1  request performs a read.
- MemWrite  in  1  request performs a write.
- RespValid  out  1  ReadData valid this cycle; single-cycle pulse per accepted read.
- ReadData  out  DATA_WIDTH  read result.
- AddrError  out  1  single-cycle pulse: accepted request had a bad address.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - ReqReady=0, RespValid=0, ReadData=0, AddrError=0.
  - Read pipeline flushed; FSM forced to INIT with the clear counter at 0.
  - Array contents are not cleared by reset itself; INIT clears them.
- FSM:
  - INIT: writes zero to word[cnt], cnt+1 per cycle; ReqReady=0. After word DEPTH-1 is written, go to RUN. INIT lasts exactly DEPTH cycles after reset release.
  - RUN: ReqReady=1 every cycle. The FSM never leaves RUN except through reset.
- Address decode:
  - Word index = Address >> log2(DATA_WIDTH/8).
  - Misaligned: any of the low log2(DATA_WIDTH/8) bits nonzero.
  - Out of range: index >= DEPTH.
- Accepted write (MemWrite=1, good address):
  - For every lane b with ByteEn[b]=1, word[index] byte b = WriteData byte b.
  - Lanes with ByteEn[b]=0 are unchanged. ByteEn=0 is a legal no-op.
- Accepted read (MemRead=1, good address):
  - Array sampled at the acceptance edge.
  - RespValid=1 and ReadData=data exactly READ_LATENCY cycles later.
  - ReadData holds its last value when RespValid=0.
- MemRead and MemWrite in the same request: write-first. The returned data is the merged post-write word.
- Back-to-back reads: one per cycle, responses in order. No stalls; there is no RespReady, so the consumer must always accept.
- Read followed next cycle by a write to the same word: the read returns the old data, because the array was sampled at accept.
- Request with MemRead=0 and MemWrite=0: accepted, no effect, no response.
- Reset asserted mid-pipeline: in-flight responses are dropped and never emitted.
- Requests presented during INIT are ignored (not accepted). The requester must hold them until ReqReady=1.

Optional Feature:
- Macro: DMEM_ERR_RESP_EN
- Defined:
  - A bad address (misaligned or out of range) suppresses the write.
  - AddrError pulses 1 the cycle after accept.
  - A bad read still produces RespValid after READ_LATENCY with ReadData=0, so response ordering is preserved.
- Undefined:
  - AddrError is tied 0.
  - Misalignment is ignored: low address bits are dropped.
  - Index wraps modulo DEPTH.
  - All accesses proceed as good accesses.

Test Plan:
- Reset release, DEPTH=32 -> ReqReady=0 for exactly 32 cycles then 1; a read of every word returns 0x00000000.
- Write 0xDEADBEEF to addr 0x8, ByteEn=4'b1111, then read 0x8 with READ_LATENCY=3 -> RespValid exactly 3 cycles after accept, ReadData=0xDEADBEEF.
- Word 0x8=0xDEADBEEF, write 0x11223344 with ByteEn=4'b0101 -> read returns 0xDE22BE44.
- Same-cycle MemRead+MemWrite to 0x10, old 0x0, new 0xA5A5A5A5 -> response 0xA5A5A5A5. Then reads to 0x0, 0x4 and 0x8 on consecutive cycles -> three in-order responses on consecutive cycles.
- DMEM_ERR_RESP_EN defined: write to 0x6 (misaligned) and read of 0x80 (index 32 ≥ DEPTH) -> AddrError pulses for both; no array change; bad read returns RespValid with 0. Undefined: write to 0x80 lands in word 0.
- Assert Rst_n low one cycle after a read accept (READ_LATENCY=2) -> no RespValid ever emitted for it; INIT restarts and runs DEPTH cycles.
